// File: rtl/dice_roll_scanner_if.sv
// Pin bundle for the dice roller: raw buttons and display polarity in,
// multiplexed 7-segment drive, BCD value and roll status out.
interface dice_roll_scanner_if #(
  parameter int NDIGITS = 3
);
  logic [6:0]           btn_in;
  logic                 cc_pol;
  logic                 seg_pol;
  logic [7:0]           seg_out;
  logic [NDIGITS-1:0]   dig_en;
  logic [4*NDIGITS-1:0] value;
  logic                 rolling;
  logic                 result_valid;

  modport master (
    output btn_in, cc_pol, seg_pol,
    input  seg_out, dig_en, value, rolling, result_valid
  );

  modport slave (
    input  btn_in, cc_pol, seg_pol,
    output seg_out, dig_en, value, rolling, result_valid
  );
endinterface

// File: rtl/dice_roll_scanner.sv
// Dice roller: debounced die-select buttons spin a BCD counter modulo the die
// size while held; the result is latched on release and shown on a scanned display.
module dice_roll_scanner #(
  parameter int NDIGITS    = 3,
  parameter int PRESCALE_W = 10,
  parameter int DEB_N      = 3,
  parameter int SCAN_W     = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  dice_roll_scanner_if.slave  bus
);

  localparam int VW  = 4 * NDIGITS;
  localparam int IW  = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int SCW = (SCAN_W > 0) ? SCAN_W : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROLL = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  function automatic logic [2:0] prio_sel(input logic [6:0] b);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (b[i]) s = 3'(i);
    end
    return s;
  endfunction

  function automatic logic [VW-1:0] die_bcd(input logic [2:0] idx);
    logic [VW-1:0] d;
    d = '0;
    case (idx)
      3'd0:    d[11:0] = 12'h004;
      3'd1:    d[11:0] = 12'h006;
      3'd2:    d[11:0] = 12'h008;
      3'd3:    d[11:0] = 12'h010;
      3'd4:    d[11:0] = 12'h012;
      3'd5:    d[11:0] = 12'h020;
      3'd6:    d[11:0] = 12'h100;
      default: d[11:0] = 12'h004;
    endcase
    return d;
  endfunction

  // Ripple borrow from digit 0 upward; a zero digit wraps to 9 and keeps borrowing.
  function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [6:0]            sync1_r, sync2_r, deb_r;
  logic [6:0][2:0]       cnt_r;
  logic [PRESCALE_W-1:0] pre_r;
  logic                  tick_s;
  logic [2:0]            sel_s;
  state_t                state_r;
  logic [VW-1:0]         die_r, value_r;
  logic                  rolling_r, result_valid_r;
  logic [SCW-1:0]        scan_cnt_r;
  logic [IW-1:0]         idx_r;
  logic                  adv_s;
  logic [NDIGITS-1:0]    blank_s, dig_s;
  logic [3:0]            cur_digit_s;
  logic [7:0]            seg_s;

  assign tick_s = (pre_r == '0);
  assign sel_s  = prio_sel(deb_r);
  assign adv_s  = (SCAN_W == 0) ? 1'b1 : (scan_cnt_r == {SCW{1'b1}});

  // Input synchroniser and free-running debounce prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 7'd0;
      sync2_r <= 7'd0;
      pre_r   <= '0;
    end else begin
      sync1_r <= bus.btn_in;
      sync2_r <= sync1_r;
      pre_r   <= pre_r + PRESCALE_W'(1);
    end
  end

  // Per-button debounce: DEB_N consecutive differing tick samples flip the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_r <= 7'd0;
      cnt_r <= '0;
    end else if (tick_s) begin
      for (int i = 0; i < 7; i++) begin
        if (sync2_r[i] != deb_r[i]) begin
          if (cnt_r[i] == 3'(DEB_N - 1)) begin
            deb_r[i] <= ~deb_r[i];
            cnt_r[i] <= 3'd0;
          end else begin
            cnt_r[i] <= cnt_r[i] + 3'd1;
          end
        end else begin
          cnt_r[i] <= 3'd0;
        end
      end
    end
  end

  // Roll state machine; the die is captured only on entry to ROLL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      die_r          <= die_bcd(3'd0);
      value_r        <= VW'(1);
      rolling_r      <= 1'b0;
      result_valid_r <= 1'b0;
    end else begin
      result_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_SHOW: begin
          if (deb_r != 7'd0) begin
            state_r   <= ST_ROLL;
            die_r     <= die_bcd(sel_s);
            value_r   <= die_bcd(sel_s);
            rolling_r <= 1'b1;
          end
        end
        ST_ROLL: begin
          if (deb_r == 7'd0) begin
            state_r        <= ST_SHOW;
            rolling_r      <= 1'b0;
            result_valid_r <= 1'b1;
          end else if (value_r == VW'(1)) begin
            value_r <= die_r;
          end else begin
            value_r <= bcd_dec(value_r);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          value_r   <= VW'(1);
          rolling_r <= 1'b0;
        end
      endcase
    end
  end

  // Display digit scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_r <= '0;
      idx_r      <= '0;
    end else begin
      scan_cnt_r <= scan_cnt_r + SCW'(1);
      if (adv_s) begin
        idx_r <= (idx_r == IW'(NDIGITS - 1)) ? '0 : idx_r + IW'(1);
      end
    end
  end

  // Leading-zero blanking, digit enables and segment decode of the scanned digit.
  always_comb begin
    logic any_nz;
    any_nz      = 1'b0;
    blank_s     = '0;
    dig_s       = '0;
    cur_digit_s = 4'd0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      any_nz = any_nz | (value_r[4*i +: 4] != 4'd0);
      if (i > 0) blank_s[i] = ~any_nz;
      else       blank_s[i] = 1'b0;
    end
    for (int i = 0; i < NDIGITS; i++) begin
      if ((idx_r == IW'(i)) && (state_r != ST_ROLL) && !blank_s[i]) dig_s[i] = bus.cc_pol;
      else                                                          dig_s[i] = ~bus.cc_pol;
      if (idx_r == IW'(i)) cur_digit_s = value_r[4*i +: 4];
      else                 cur_digit_s = cur_digit_s;
    end
    if (bus.seg_pol) seg_s = {1'b0, seg_decode(cur_digit_s)};
    else             seg_s = ~{1'b0, seg_decode(cur_digit_s)};
  end

  assign bus.seg_out      = seg_s;
  assign bus.dig_en       = dig_s;
  assign bus.value        = value_r;
  assign bus.rolling      = rolling_r;
  assign bus.result_valid = result_valid_r;

endmodule

// File: tb/tb_dice_roll_scanner.sv
// Directed bench for dice_roll_scanner with a small BCD/roll/display model.
module tb_dice_roll_scanner;
  localparam int ND = 3;
  localparam int PW = 3;
  localparam int DN = 3;
  localparam int SW = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc;
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   exp_v     = 1;

  dice_roll_scanner_if #(.NDIGITS(ND)) bus ();

  dice_roll_scanner #(.NDIGITS(ND), .PRESCALE_W(PW), .DEB_N(DN), .SCAN_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Scan index model: advances every clock after reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  default: return 7'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input logic [11:0] v, input int idx, input logic sp);
    logic [3:0] d;
    d = v[4*idx +: 4];
    return sp ? {1'b0, seg7(d)} : ~{1'b0, seg7(d)};
  endfunction

  function automatic logic [2:0] exp_dig(input logic [11:0] v, input int idx, input logic cc, input bit roll);
    logic [2:0] r;
    bit shown;
    shown = (idx == 0) || (idx == 1 && v[11:4] != 8'd0) || (idx == 2 && v[11:8] != 4'd0);
    r = {3{~cc}};
    if (shown && !roll) r[idx] = cc;
    return r;
  endfunction

  task automatic check_display(input string tag, input logic [11:0] v, input logic cc, input logic sp, input bit roll);
    int idx;
    idx = cyc % 3;
    chk({tag, "_dig"}, 32'(bus.dig_en), 32'(exp_dig(v, idx, cc, roll)));
    chk({tag, "_seg"}, 32'(bus.seg_out), 32'(exp_seg(v, idx, sp)));
  endtask

  task automatic step_model(input int die);
    exp_v = (exp_v == 1) ? die : exp_v - 1;
  endtask

  task automatic wait_rise(input string tag, input int die);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 48 && !seen; i++) begin
      @(negedge clk);
      if (bus.rolling === 1'b1) seen = 1'b1;
    end
    chk({tag, "_rise"}, 32'(seen), 32'd1);
    exp_v = die;
    chk({tag, "_load"}, 32'(bus.value), 32'(to_bcd(die)));
  endtask

  task automatic roll_cycles(input string tag, input int die, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step_model(die);
      chk({tag, "_val"}, 32'(bus.value), 32'(to_bcd(exp_v)));
      chk({tag, "_roll"}, 32'(bus.rolling), 32'd1);
      check_display(tag, to_bcd(exp_v), 1'b1, 1'b1, 1'b1);
    end
  endtask

  task automatic release_and_show(input string tag, input int die);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 48 && !done; i++) begin
      @(negedge clk);
      if (bus.rolling === 1'b1) begin
        step_model(die);
        chk({tag, "_rel_val"}, 32'(bus.value), 32'(to_bcd(exp_v)));
        chk({tag, "_rel_rv"}, 32'(bus.result_valid), 32'd0);
      end else begin
        done = 1'b1;
        chk({tag, "_rv_pulse"}, 32'(bus.result_valid), 32'd1);
        chk({tag, "_frozen"}, 32'(bus.value), 32'(to_bcd(exp_v)));
      end
    end
    chk({tag, "_show"}, 32'(done), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, "_rv_low"}, 32'(bus.result_valid), 32'd0);
      chk({tag, "_held"}, 32'(bus.value), 32'(to_bcd(exp_v)));
      check_display({tag, "_disp"}, to_bcd(exp_v), 1'b1, 1'b1, 1'b0);
    end
  endtask

  task automatic quiet_cycles(input string tag, input int n, input logic cc, input logic sp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_roll"}, 32'(bus.rolling), 32'd0);
      chk({tag, "_val"}, 32'(bus.value), 32'h001);
      chk({tag, "_rv"}, 32'(bus.result_valid), 32'd0);
      check_display(tag, 12'h001, cc, sp, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.btn_in = 7'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.btn_in  = 7'd0;
    bus.cc_pol  = 1'b1;
    bus.seg_pol = 1'b1;

    // 1: idle after reset shows "1" on digit 0 only
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet_cycles("t1", 6, 1'b1, 1'b1);

    // 2: d20 held, wraps, released
    bus.btn_in[5] = 1'b1;
    wait_rise("t2", 20);
    roll_cycles("t2", 20, 45);
    bus.btn_in = 7'd0;
    release_and_show("t2", 20);

    // 3: d100 from SHOW, several wraps through 001 -> 100
    bus.btn_in[6] = 1'b1;
    wait_rise("t3", 100);
    roll_cycles("t3", 100, 230);
    bus.btn_in = 7'd0;
    release_and_show("t3", 100);

    // 4: bouncing and short pulses never start a roll
    do_reset();
    for (int k = 0; k < 10; k++) begin
      bus.btn_in[0] = (k % 2 == 0);
      quiet_cycles("t4_bounce", 8, 1'b1, 1'b1);
    end
    bus.btn_in[0] = 1'b0;
    quiet_cycles("t4_gap", 16, 1'b1, 1'b1);
    bus.btn_in[0] = 1'b1;
    quiet_cycles("t4_pulse", 15, 1'b1, 1'b1);
    bus.btn_in[0] = 1'b0;
    quiet_cycles("t4_after", 40, 1'b1, 1'b1);

    // 5: d6 wins priority over d10; late d100 press is ignored
    bus.btn_in = 7'b0001010;
    wait_rise("t5", 6);
    roll_cycles("t5", 6, 10);
    bus.btn_in[6] = 1'b1;
    roll_cycles("t5_late", 6, 60);
    bus.btn_in = 7'd0;
    release_and_show("t5", 6);

    // 6: reset mid-roll, then inverted polarities
    bus.btn_in[2] = 1'b1;
    wait_rise("t6", 8);
    roll_cycles("t6", 8, 5);
    @(negedge clk);
    rst_n       = 1'b0;
    bus.cc_pol  = 1'b0;
    bus.seg_pol = 1'b0;
    #1;
    chk("t6_rst_roll", 32'(bus.rolling), 32'd0);
    chk("t6_rst_val", 32'(bus.value), 32'h001);
    chk("t6_rst_rv", 32'(bus.result_valid), 32'd0);
    bus.btn_in = 7'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet_cycles("t6_inv", 40, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
